ncor_cnt_ingress: RTL and testbench

// - Upstream feeder for the ncor1a 1R1W counter core: buffers per-port counter-update requests, coalesces

---
 rtl/ncor_pkg.sv | 28 ++
 rtl/ncor_coalesce_fifo.sv | 114 +++++++++++
 rtl/ncor_cnt_ingress.sv | 83 ++++++++
 tb/tb_ncor_cnt_ingress.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ncor_pkg.sv
// Shared types, default constants and the saturating adder for the ncor counter ingress.
package ncor_pkg;

  localparam int unsigned DefWidth    = 32;
  localparam int unsigned DefNumctpt  = 2;
  localparam int unsigned DefNumaddr  = 8192;
  localparam int unsigned DefBitaddr  = 13;
  localparam int unsigned DefFifodpth = 4;
  localparam int unsigned DefBitfifo  = 2;
  localparam int unsigned DefMaxout   = 4;

  // Request entry at the default geometry
  typedef struct packed {
    logic [DefBitaddr-1:0] adr;
    logic [DefWidth-1:0]   imm;
  } req_entry_t;

  // Unsigned add of two width-bit values (width <= 64), clamped to 2^width-1
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned width);
    logic [64:0] sum;
    logic [64:0] max;
    sum = {1'b0, a} + {1'b0, b};
    max = (65'd1 << width) - 65'd1;
    return (sum > max) ? max[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/ncor_coalesce_fifo.sv
// One counter port: request FIFO with tail coalescing, issue throttling and credit tracking.
module ncor_coalesce_fifo
  import ncor_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned BITADDR  = DefBitaddr,
  parameter int unsigned FIFODPTH = DefFifodpth,
  parameter int unsigned BITFIFO  = DefBitfifo,
  parameter int unsigned MAXOUT   = DefMaxout
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ready,
  input  logic               req_vld,
  input  logic [BITADDR-1:0] req_adr,
  input  logic [WIDTH-1:0]   req_imm,
  output logic               req_rdy,
  output logic               issue,
  output logic [BITADDR-1:0] head_adr,
  output logic [WIDTH-1:0]   head_imm,
  input  logic               ct_vld,
  input  logic               ct_serr,
  input  logic               ct_derr,
  output logic               sat_flag,
  output logic               err_flag,
  output logic               serr_flag,
  output logic               port_idle
);

  typedef struct packed {
    logic [BITADDR-1:0] adr;
    logic [WIDTH-1:0]   imm;
  } entry_t;

  entry_t             mem_q [FIFODPTH];
  logic [BITFIFO-1:0] wr_ptr_q, rd_ptr_q, tail_ptr;
  logic [BITFIFO:0]   cnt_q, cnt_d;
  logic [3:0]         out_q, out_d;
  logic               nonempty, accept, coal, push, pop, dec;
  logic [WIDTH:0]     raw_sum;
  logic [63:0]        sum_wide;
  logic [WIDTH-1:0]   sum_val;
  logic               sum_sat;

  assign nonempty = (cnt_q != '0);
  assign req_rdy  = (cnt_q != (BITFIFO+1)'(FIFODPTH));
  assign accept   = req_vld & req_rdy;
  assign pop      = nonempty & ready & (out_q < 4'(MAXOUT));
  assign tail_ptr = wr_ptr_q - 1'b1;

  // The tail may only absorb a request if it is not leaving the FIFO this cycle
  assign coal = accept & nonempty & (mem_q[tail_ptr].adr == req_adr) &
                ~(pop & (cnt_q == (BITFIFO+1)'(1)));
  assign push = accept & ~coal;

  assign raw_sum  = {1'b0, mem_q[tail_ptr].imm} + {1'b0, req_imm};
  assign sum_sat  = raw_sum[WIDTH];
  assign sum_wide = sat_add(64'(mem_q[tail_ptr].imm), 64'(req_imm), WIDTH);
  assign sum_val  = sum_wide[WIDTH-1:0];

  assign dec       = ct_vld & (out_q != '0);
  assign issue     = pop;
  assign head_adr  = mem_q[rd_ptr_q].adr;
  assign head_imm  = mem_q[rd_ptr_q].imm;
  assign port_idle = ~nonempty & (out_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    out_d = out_q;
    unique case ({pop, dec})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      sat_flag  <= 1'b0;
      err_flag  <= 1'b0;
      serr_flag <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (coal && sum_sat) sat_flag <= 1'b1;
      // A completion with nothing outstanding is a protocol error
      if (ct_vld && (ct_derr || (out_q == '0))) err_flag <= 1'b1;
      if (ct_vld && ct_serr) serr_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{adr: req_adr, imm: req_imm};
    end else if (coal) begin
      mem_q[tail_ptr].imm <= sum_val;
    end
  end

endmodule

// File: rtl/ncor_cnt_ingress.sv
// Ingress feeder for the ncor1a counter core: per-port coalescing FIFOs with registered issue.
module ncor_cnt_ingress
  import ncor_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned NUMCTPT  = DefNumctpt,
  parameter int unsigned NUMADDR  = DefNumaddr,
  parameter int unsigned BITADDR  = DefBitaddr,
  parameter int unsigned FIFODPTH = DefFifodpth,
  parameter int unsigned BITFIFO  = DefBitfifo,
  parameter int unsigned MAXOUT   = DefMaxout
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ready,
  input  logic [NUMCTPT-1:0]         req_vld,
  input  logic [NUMCTPT*BITADDR-1:0] req_adr,
  input  logic [NUMCTPT*WIDTH-1:0]   req_imm,
  output logic [NUMCTPT-1:0]         req_rdy,
  output logic [NUMCTPT-1:0]         cnt,
  output logic [NUMCTPT*BITADDR-1:0] ct_adr,
  output logic [NUMCTPT*WIDTH-1:0]   imm,
  input  logic [NUMCTPT-1:0]         ct_vld,
  input  logic [NUMCTPT-1:0]         ct_serr,
  input  logic [NUMCTPT-1:0]         ct_derr,
  output logic [NUMCTPT-1:0]         sat_flag,
  output logic [NUMCTPT-1:0]         err_flag,
  output logic [NUMCTPT-1:0]         serr_flag,
  output logic                       idle
);

  logic [NUMCTPT-1:0]         issue, port_idle;
  logic [NUMCTPT*BITADDR-1:0] head_adr;
  logic [NUMCTPT*WIDTH-1:0]   head_imm;

  for (genvar p = 0; p < NUMCTPT; p++) begin : g_port
    ncor_coalesce_fifo #(
      .WIDTH    (WIDTH),
      .BITADDR  (BITADDR),
      .FIFODPTH (FIFODPTH),
      .BITFIFO  (BITFIFO),
      .MAXOUT   (MAXOUT)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .ready     (ready),
      .req_vld   (req_vld[p]),
      .req_adr   (req_adr[p*BITADDR +: BITADDR]),
      .req_imm   (req_imm[p*WIDTH +: WIDTH]),
      .req_rdy   (req_rdy[p]),
      .issue     (issue[p]),
      .head_adr  (head_adr[p*BITADDR +: BITADDR]),
      .head_imm  (head_imm[p*WIDTH +: WIDTH]),
      .ct_vld    (ct_vld[p]),
      .ct_serr   (ct_serr[p]),
      .ct_derr   (ct_derr[p]),
      .sat_flag  (sat_flag[p]),
      .err_flag  (err_flag[p]),
      .serr_flag (serr_flag[p]),
      .port_idle (port_idle[p])
    );
  end

  // Core-facing outputs: strobe each cycle, address/immediate hold between issues
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      ct_adr <= '0;
      imm    <= '0;
    end else begin
      cnt <= issue;
      for (int p = 0; p < int'(NUMCTPT); p++) begin
        if (issue[p]) begin
          ct_adr[p*BITADDR +: BITADDR] <= head_adr[p*BITADDR +: BITADDR];
          imm[p*WIDTH +: WIDTH]        <= head_imm[p*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign idle = &port_idle;

endmodule

// File: tb/tb_ncor_cnt_ingress.sv
// Scoreboard bench for ncor_cnt_ingress at the default two-port geometry.
module tb_ncor_cnt_ingress;
  import ncor_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned NP = 2;
  localparam int unsigned BA = 13;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ready = 1'b0;
  logic [NP-1:0]    req_vld = '0;
  logic [NP*BA-1:0] req_adr = '0;
  logic [NP*W-1:0]  req_imm = '0;
  logic [NP-1:0]    req_rdy;
  logic [NP-1:0]    cnt;
  logic [NP*BA-1:0] ct_adr;
  logic [NP*W-1:0]  imm;
  logic [NP-1:0]    ct_vld = '0;
  logic [NP-1:0]    ct_serr = '0;
  logic [NP-1:0]    ct_derr = '0;
  logic [NP-1:0]    sat_flag, err_flag, serr_flag;
  logic             idle;

  int tests_run = 0;
  int failed = 0;
  int pulses [NP];
  req_entry_t exp_q [NP][$];

  always #5 clk = ~clk;

  ncor_cnt_ingress dut (
    .clk       (clk),
    .rst       (rst),
    .ready     (ready),
    .req_vld   (req_vld),
    .req_adr   (req_adr),
    .req_imm   (req_imm),
    .req_rdy   (req_rdy),
    .cnt       (cnt),
    .ct_adr    (ct_adr),
    .imm       (imm),
    .ct_vld    (ct_vld),
    .ct_serr   (ct_serr),
    .ct_derr   (ct_derr),
    .sat_flag  (sat_flag),
    .err_flag  (err_flag),
    .serr_flag (serr_flag),
    .idle      (idle)
  );

  // Every issue strobe must match the oldest expected entry of its port
  always @(negedge clk) begin
    req_entry_t got, want;
    if (rst) begin
      for (int p = 0; p < int'(NP); p++) begin
        if (cnt[p]) begin
          pulses[p]++;
          tests_run++;
          got = {ct_adr[p*BA +: BA], imm[p*W +: W]};
          if (exp_q[p].size() == 0) begin
            failed++;
            $display("FAIL unexpected_cnt port%0d: got adr=%0d imm=%h, required no issue",
                     p, got.adr, got.imm);
          end else begin
            want = exp_q[p].pop_front();
            if (got !== want) begin
              failed++;
              $display("FAIL issue_data port%0d: got adr=%0d imm=%h, required adr=%0d imm=%h",
                       p, got.adr, got.imm, want.adr, want.imm);
            end
          end
        end
      end
    end
  end

  function automatic req_entry_t mk(input int adr, input logic [W-1:0] v);
    mk.adr = BA'(adr);
    mk.imm = v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input int adr, input logic [W-1:0] v);
    req_vld[p] = 1'b1;
    req_adr[p*BA +: BA] = BA'(adr);
    req_imm[p*W +: W] = v;
    tick();
    req_vld[p] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    rst = 1'b1;
    tick();
    tests_run++;
    if (req_rdy !== 2'b11) begin failed++; $display("FAIL reset_rdy: got %b required 11", req_rdy); end
    tests_run++;
    if (cnt !== 2'b00) begin failed++; $display("FAIL reset_cnt: got %b required 00", cnt); end
    tests_run++;
    if (idle !== 1'b1) begin failed++; $display("FAIL reset_idle: got %b required 1", idle); end
    tests_run++;
    if (ct_adr !== '0 || imm !== '0) begin
      failed++; $display("FAIL reset_data: got adr=%h imm=%h required 0", ct_adr, imm);
    end
    tests_run++;
    if ({sat_flag, err_flag, serr_flag} !== '0) begin
      failed++; $display("FAIL reset_flags: got %b required 0", {sat_flag, err_flag, serr_flag});
    end
  endtask

  task automatic test_coalesce();
    int p0;
    ready = 1'b0;
    send(0, 5, 32'd1);
    send(0, 5, 32'd2);
    tests_run++;
    if (req_rdy[0] !== 1'b1 || idle !== 1'b0) begin
      failed++; $display("FAIL coal_state: got rdy=%b idle=%b required 1 0", req_rdy[0], idle);
    end
    exp_q[0].push_back(mk(5, 32'd3));
    p0 = pulses[0];
    ready = 1'b1;
    repeat (4) tick();
    tests_run++;
    if (pulses[0] - p0 !== 1) begin
      failed++; $display("FAIL coal_pulses: got %0d required 1", pulses[0] - p0);
    end
    ct_vld[0] = 1'b1;
    tick();
    ct_vld[0] = 1'b0;
    tests_run++;
    if (idle !== 1'b1 || err_flag !== 2'b00) begin
      failed++; $display("FAIL coal_done: got idle=%b err=%b required 1 00", idle, err_flag);
    end
  endtask

  task automatic test_fill_credit();
    int p1;
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(1, 10 + i, W'(i + 1));
      exp_q[1].push_back(mk(10 + i, W'(i + 1)));
    end
    tests_run++;
    if (req_rdy !== 2'b01) begin failed++; $display("FAIL full_rdy: got %b required 01", req_rdy); end
    p1 = pulses[1];
    ready = 1'b1;
    repeat (6) tick();
    tests_run++;
    if (pulses[1] - p1 !== 4) begin
      failed++; $display("FAIL credit_fill: got %0d required 4", pulses[1] - p1);
    end
    send(1, 14, 32'd5);
    exp_q[1].push_back(mk(14, 32'd5));
    repeat (4) tick();
    tests_run++;
    if (pulses[1] - p1 !== 4 || idle !== 1'b0) begin
      failed++; $display("FAIL credit_stall: got %0d idle=%b required 4 0", pulses[1] - p1, idle);
    end
    ct_vld[1] = 1'b1;
    tick();
    ct_vld[1] = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (pulses[1] - p1 !== 5) begin
      failed++; $display("FAIL credit_return: got %0d required 5", pulses[1] - p1);
    end
    ct_vld[1] = 1'b1;
    repeat (4) tick();
    ct_vld[1] = 1'b0;
    tests_run++;
    if (idle !== 1'b1 || err_flag[1] !== 1'b0) begin
      failed++; $display("FAIL credit_drain: got idle=%b err=%b required 1 0", idle, err_flag[1]);
    end
  endtask

  task automatic test_saturate();
    ready = 1'b0;
    send(0, 7, 32'hFFFF_FFF0);
    tests_run++;
    if (sat_flag !== 2'b00) begin failed++; $display("FAIL sat_early: got %b required 00", sat_flag); end
    send(0, 7, 32'h20);
    tests_run++;
    if (sat_flag !== 2'b01) begin failed++; $display("FAIL sat_flag: got %b required 01", sat_flag); end
    exp_q[0].push_back(mk(7, 32'hFFFF_FFFF));
    ready = 1'b1;
    repeat (3) tick();
    ct_vld[0] = 1'b1;
    tick();
    ct_vld[0] = 1'b0;
    tests_run++;
    if (idle !== 1'b1 || sat_flag !== 2'b01) begin
      failed++; $display("FAIL sat_sticky: got idle=%b sat=%b required 1 01", idle, sat_flag);
    end
  endtask

  task automatic test_back_to_back();
    int p0, p1;
    p0 = pulses[0];
    p1 = pulses[1];
    ready = 1'b1;
    // Port0 gets a completion alongside each issue from cycle 2; port1 gets none
    for (int k = 0; k < 6; k++) begin
      req_vld = (k < 5) ? 2'b11 : 2'b00;
      req_adr = {BA'(40 + k), BA'(30 + k)};
      req_imm = {W'(k + 10), W'(k + 1)};
      if (k < 5) begin
        exp_q[0].push_back(mk(30 + k, W'(k + 1)));
        exp_q[1].push_back(mk(40 + k, W'(k + 10)));
      end
      ct_vld = {1'b0, (k >= 2)};
      tick();
    end
    req_vld = '0;
    ct_vld = '0;
    tick();
    tests_run++;
    if (pulses[0] - p0 !== 5) begin
      failed++; $display("FAIL b2b_port0: got %0d required 5", pulses[0] - p0);
    end
    tests_run++;
    if (pulses[1] - p1 !== 4 || idle !== 1'b0) begin
      failed++; $display("FAIL b2b_port1: got %0d idle=%b required 4 0", pulses[1] - p1, idle);
    end
    ct_vld = 2'b11;
    tick();
    ct_vld = 2'b10;
    repeat (4) tick();
    ct_vld = '0;
    tick();
    tests_run++;
    if (pulses[1] - p1 !== 5 || idle !== 1'b1 || err_flag !== 2'b00) begin
      failed++;
      $display("FAIL b2b_drain: got %0d idle=%b err=%b required 5 1 00",
               pulses[1] - p1, idle, err_flag);
    end
  endtask

  task automatic test_err_flags();
    ct_vld[1] = 1'b1;
    tick();
    ct_vld[1] = 1'b0;
    tests_run++;
    if (err_flag !== 2'b10 || idle !== 1'b1) begin
      failed++; $display("FAIL err_underflow: got err=%b idle=%b required 10 1", err_flag, idle);
    end
    send(0, 50, 32'd1);
    exp_q[0].push_back(mk(50, 32'd1));
    repeat (2) tick();
    ct_vld[0] = 1'b1;
    ct_serr[0] = 1'b1;
    tick();
    ct_vld[0] = 1'b0;
    ct_serr[0] = 1'b0;
    tests_run++;
    if (serr_flag !== 2'b01 || err_flag !== 2'b10) begin
      failed++; $display("FAIL serr: got serr=%b err=%b required 01 10", serr_flag, err_flag);
    end
    send(0, 51, 32'd2);
    exp_q[0].push_back(mk(51, 32'd2));
    repeat (2) tick();
    ct_vld[0] = 1'b1;
    ct_derr[0] = 1'b1;
    tick();
    ct_vld[0] = 1'b0;
    ct_derr[0] = 1'b0;
    tests_run++;
    if (err_flag !== 2'b11 || serr_flag !== 2'b01 || idle !== 1'b1) begin
      failed++;
      $display("FAIL derr: got err=%b serr=%b idle=%b required 11 01 1", err_flag, serr_flag, idle);
    end
  endtask

  task automatic test_mid_reset();
    ready = 1'b1;
    req_vld = 2'b11;
    req_adr = {BA'(70), BA'(60)};
    req_imm = {W'(7), W'(6)};
    exp_q[0].push_back(mk(60, 32'd6));
    exp_q[1].push_back(mk(70, 32'd7));
    tick();
    req_vld = '0;
    tick();
    ready = 1'b0;
    send(0, 61, 32'd1);
    send(1, 71, 32'd1);
    tick();
    tests_run++;
    if (idle !== 1'b0) begin failed++; $display("FAIL pre_reset_idle: got %b required 0", idle); end
    rst = 1'b0;
    tick();
    tests_run++;
    if (req_rdy !== 2'b11 || idle !== 1'b1 || cnt !== 2'b00) begin
      failed++; $display("FAIL mid_reset_state: got rdy=%b idle=%b cnt=%b required 11 1 00",
                         req_rdy, idle, cnt);
    end
    tests_run++;
    if ({sat_flag, err_flag, serr_flag} !== '0 || ct_adr !== '0 || imm !== '0) begin
      failed++; $display("FAIL mid_reset_clear: got flags=%b adr=%h imm=%h required 0",
                         {sat_flag, err_flag, serr_flag}, ct_adr, imm);
    end
    rst = 1'b1;
    ready = 1'b1;
    repeat (5) tick();
    tests_run++;
    if (exp_q[0].size() != 0 || exp_q[1].size() != 0 || idle !== 1'b1) begin
      failed++; $display("FAIL leftover: got q0=%0d q1=%0d idle=%b required 0 0 1",
                         exp_q[0].size(), exp_q[1].size(), idle);
    end
  endtask

  initial begin
    pulses[0] = 0;
    pulses[1] = 0;
    test_reset();
    test_coalesce();
    test_fill_credit();
    test_saturate();
    test_back_to_back();
    test_err_flags();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
